wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage of the 32-bit RISC-V pipeline; the single writer driving the register file write port (write_en/write_addr/write_data).
- Accepts retiring instructions from the MEM stage through a valid/ready handshake.
- Selects the result source and aligns and extends load data.
- Stalls the MEM stage while waiting for a late data-memory response.
- Counts retired instructions.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept an instruction this cycle
- in_reg_write  in  1  instruction writes rd
- in_rd  in  5  destination register index
- in_wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved
- in_alu_result  in  32  ALU result; for loads, the effective address
- in_pc_plus4  in  32  link value
- in_funct3  in  3  load size/sign
- dmem_rsp_valid  in  1  load data available
- dmem_rsp_data  in  32  aligned 32-bit word read from data memory
- write_en  out  1  register file write enable (registered)
- write_addr  out  5  register file write address (registered)
- write_data  out  32  register file write data (registered)
- load_err  out  1  one-cycle pulse: misaligned or illegal load retired, write suppressed
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - State RUN; in_ready=1.
  - write_en=0, write_addr=0, write_data=0, load_err=0, instret=0.
  - Any waiting load is discarded.
- States: RUN and WAIT_LOAD.
  - in_ready is 1 in RUN and 0 in WAIT_LOAD, combinational from state only.
- Accept occurs at a rising edge with in_valid && in_ready.
- Accepting a non-load (wb_sel 00/10/11):
  - Result is alu_result (00), pc_plus4 (10), or alu_result (11).
  - Outputs register on the accept edge: write_en is high for exactly the next cycle.
  - Latency is one cycle; back-to-back accepts give back-to-back write pulses.
- Accepting a load (wb_sel 01):
  - If dmem_rsp_valid=1 in the accept cycle, the load completes like a non-load, using dmem_rsp_data.
  - Otherwise, latch rd, reg_write, funct3 and address[1:0], and go to WAIT_LOAD.
- In WAIT_LOAD:
  - On the first edge with dmem_rsp_valid=1, capture the data, drive the write pulse registered on that edge, and return to RUN.
  - in_ready is high again in the cycle write_en is asserted.
- dmem_rsp_valid is ignored in RUN except in a load accept cycle.
- in_valid is ignored in WAIT_LOAD.
- Load extraction, with off=address[1:0]:
  - LB(000) and LBU(100): byte at bits [8*off+7:8*off], sign- or zero-extended to 32 bits.
  - LH(001) and LHU(101): off 0 takes bits [15:0], off 2 takes bits [31:16], sign- or zero-extended. Off 1 or 3 is misaligned.
  - LW(010): off 0 only; any other off is misaligned.
  - funct3 011/110/111 is illegal.
  - Misaligned or illegal: write_en stays 0 and load_err pulses for one cycle at the completion slot. The instruction still retires.
- write_en = reg_write && (rd != 0).
  - write_addr and write_data are updated at every completion, even when write_en=0.
  - Otherwise write_addr and write_data hold their value.
- instret increments by 1 at each completion edge, including no-write and errored loads.
  - Wraps from all-ones to 0.
- Reset asserted mid-WAIT_LOAD: returns to RUN and the load is never written.
  - A dmem_rsp_valid arriving after reset deassertion is ignored unless it falls in a load accept cycle.

Test Plan:
- ALU op: accept rd=5, reg_write=1, wb_sel=00, alu_result=0x0000_1234 -> next cycle write_en=1, write_addr=5, write_data=0x0000_1234; instret=1.
- Back-to-back: three ALU ops on consecutive cycles to rd=1,2,3 -> write_en high 3 consecutive cycles, addresses 1,2,3; instret=3; in_ready stays 1.
- Late load: LB, addr=0x...03, dmem_rsp_valid low for 4 cycles then data=0x80FF_0000 -> in_ready=0 for 4 cycles, then write_data=0xFFFF_FF80; LBU with the same data gives 0x0000_0080.
- Halfword and misalign:
  - LHU off=2, data=0xBEEF_1234 -> write_data=0x0000_BEEF.
  - LH off=2, same data -> write_data=0xFFFF_BEEF.
  - LW off=1 -> write_en=0, load_err pulses 1 cycle, instret still increments.
- x0 and link: wb_sel=10, rd=0, pc_plus4=0x104 -> write_en=0; with rd=1 -> write_data=0x0000_0104.
- Reset mid-wait: enter WAIT_LOAD, pull rst_n low asynchronously -> in_ready=1, write_en=0, instret=0 immediately; a late dmem_rsp_valid produces no write.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: selects the result source, aligns and extends load data,
// waits for late load responses and counts retired instructions.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // retiring instruction from MEM
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [2:0]       in_funct3,
  // data memory response
  input  logic             dmem_rsp_valid,
  input  logic [XLEN-1:0]  dmem_rsp_data,
  // register file write port
  output logic             write_en,
  output logic [4:0]       write_addr,
  output logic [XLEN-1:0]  write_data,
  output logic             load_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic {
    RUN,
    WAIT_LOAD
  } state_e;

  state_e state_q, state_d;

  logic       rw_q, rw_d;
  logic [4:0] rd_q, rd_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;

  logic             we_q, we_d;
  logic [4:0]       wa_q, wa_d;
  logic [XLEN-1:0]  wd_q, wd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_ready   = (state_q == RUN);
  assign write_en   = we_q;
  assign write_addr = wa_q;
  assign write_data = wd_q;
  assign load_err   = err_q;
  assign instret    = cnt_q;

  // load extraction; a waiting load uses its latched size and offset
  logic [2:0]      ld_f3;
  logic [1:0]      ld_off;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_val;
  logic            ld_err;

  always_comb begin
    ld_f3  = in_funct3;
    ld_off = in_alu_result[1:0];
    if (state_q == WAIT_LOAD) begin
      ld_f3  = f3_q;
      ld_off = off_q;
    end
    ld_b = dmem_rsp_data[7:0];
    unique case (ld_off)
      2'd0: ld_b = dmem_rsp_data[7:0];
      2'd1: ld_b = dmem_rsp_data[15:8];
      2'd2: ld_b = dmem_rsp_data[23:16];
      2'd3: ld_b = dmem_rsp_data[31:24];
      default: ld_b = dmem_rsp_data[7:0];
    endcase
    ld_h   = ld_off[1] ? dmem_rsp_data[31:16] : dmem_rsp_data[15:0];
    ld_val = '0;
    ld_err = 1'b0;
    unique case (ld_f3)
      3'b000: ld_val = {{24{ld_b[7]}}, ld_b};
      3'b100: ld_val = {24'd0, ld_b};
      3'b001: begin
        ld_val = {{16{ld_h[15]}}, ld_h};
        ld_err = ld_off[0];
      end
      3'b101: begin
        ld_val = {16'd0, ld_h};
        ld_err = ld_off[0];
      end
      3'b010: begin
        ld_val = dmem_rsp_data;
        ld_err = (ld_off != 2'd0);
      end
      default: ld_err = 1'b1;
    endcase
  end

  logic            done;
  logic            c_rw;
  logic [4:0]      c_rd;
  logic [XLEN-1:0] c_val;
  logic            c_err;

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    off_d   = off_q;
    done    = 1'b0;
    c_rw    = in_reg_write;
    c_rd    = in_rd;
    c_val   = in_alu_result;
    c_err   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (in_valid) begin
          if (in_wb_sel == 2'b01) begin
            if (dmem_rsp_valid) begin
              done  = 1'b1;
              c_val = ld_val;
              c_err = ld_err;
            end else begin
              state_d = WAIT_LOAD;
              rw_d    = in_reg_write;
              rd_d    = in_rd;
              f3_d    = in_funct3;
              off_d   = in_alu_result[1:0];
            end
          end else begin
            done = 1'b1;
            if (in_wb_sel == 2'b10) c_val = in_pc_plus4;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rsp_valid) begin
          state_d = RUN;
          done    = 1'b1;
          c_rw    = rw_q;
          c_rd    = rd_q;
          c_val   = ld_val;
          c_err   = ld_err;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    we_d  = 1'b0;
    err_d = 1'b0;
    wa_d  = wa_q;
    wd_d  = wd_q;
    cnt_d = cnt_q;
    if (done) begin
      we_d  = c_rw && (c_rd != 5'd0) && !c_err;
      err_d = c_err;
      wa_d  = c_rd;
      wd_d  = c_err ? '0 : c_val;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
